vector_mem_arbiter: RTL and testbench
=====================================

Name: vector_mem_arbiter

Overview:
- Sequences and shares the single-port data memory between two requesters: client 0 (vector/scalar load path) and client 1 (vector/scalar store path).
- Grants one client at a time by round-robin and latches its request.
- Performs a scalar (1-item) or vector (I-item) burst at consecutive addresses, collects read data into a vector register, and signals completion per client.
- Sits between the execute-stage memory units and the data RAM.

Parameters:
- I, 20, number of items in a vector.
- L, 32, item length in bits.
- A, 6, memory address width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; asynchronous, active-high.
- req  in  2  per-client request; held high until the matching ack.
- op_store  in  2  per client: 1 = store, 0 = load.
- op_vector  in  2  per client: 1 = vector (I items), 0 = scalar (1 item).
- base_address  in  2xA  per-client base address.
- wdata  in  2xIxL  per-client store data; item k goes to base+k.
- ack  out  2  one-cycle pulse; request latched, client may drop or change its inputs.
- done  out  2  one-cycle pulse to the granted client when its transfer completes.
- busy  out  1  high whenever state is not IDLE.
- mem_address  out  A  memory address.
- mem_we  out  1  memory write enable.
- mem_wdata  out  L  memory write data.
- mem_rdata  in  L  memory read data; synchronous, valid the cycle after the address is presented.
- vector_data  out  IxL  load result register.
- scalar_data  out  L  equals vector_data[0].

Behaviour:
- Reset values (asynchronous, immediate): state IDLE; ack, done, busy, mem_we all 0; mem_address 0; mem_wdata 0; vector_data all 0; item counter 0; last_grant = 1, so client 0 wins the first tie.
- Reset mid-transfer aborts the transfer. No done is issued, mem_we drops at once, and captured data is cleared.
- FSM states:
  - IDLE: if any req is high, grant and latch, then go to XFER. Otherwise stay.
  - XFER: issue item idx at mem_address = base + idx (mod 2^A); idx runs 0..N-1 with N = I if vector, else 1. After idx = N-1: a load goes to DRAIN, a store goes to DONE.
  - DRAIN: load only. Captures the last read item, then goes to DONE.
  - DONE: done[g] = 1 for one cycle, then go to IDLE. There is no arbitration in DONE.
- Arbitration:
  - Only client 0 requesting: grant 0. Only client 1 requesting: grant 1.
  - Both requesting: grant the client not equal to last_grant.
  - last_grant updates on each grant.
  - ack[g] is asserted in the IDLE cycle where the grant is made. Op, base and wdata are latched on that edge.
- Loads:
  - mem_we = 0 throughout.
  - mem_rdata sampled in cycle t+1 is written to vector_data[idx issued at t].
  - Scalar load writes item 0 only; items 1..I-1 keep their previous values.
  - vector_data holds its value between transfers and is not cleared by a new grant.
- Stores:
  - mem_we = 1 only in XFER cycles; mem_wdata = latched wdata[idx].
  - Scalar store writes wdata[0].
  - Stores never modify vector_data.
- Latency, counted from the ack cycle (cycle 0):
  - Vector load: done at cycle I+2.
  - Scalar load: done at cycle 3.
  - Vector store: done at cycle I+1.
  - Scalar store: done at cycle 2.
  - vector_data is final in the done cycle.
- Outside XFER, mem_address = latched base and mem_we = 0.
- Address wraps modulo 2^A; no error is flagged.
- A req that rises while busy waits; it is not acked until IDLE.
- A req still high after done is re-arbitrated in the following IDLE cycle. Minimum gap between transfers is one IDLE cycle.
- req dropped before ack is legal: no grant is made if req is low in IDLE.
- The counter must hold 0..I; width is clog2(I+1).

Test Plan:
- Vector load: memory preloaded with mem[k] = 100+k. Client 0 issues load, vector, base 8 → ack cycle 0; mem_address 8..27 in cycles 1..20; done[0] at cycle 22; vector_data[k] = 100+(k+8), scalar_data = 108.
- Scalar store then scalar load: client 1 stores scalar, base 5, wdata[0] = 32'hDEADBEEF → mem_we for exactly one cycle at address 5, done[1] at cycle 2. Client 0 then loads scalar, base 5 → vector_data[0] = 32'hDEADBEEF, other items unchanged.
- Contention: both req high from reset → client 0 acked first. Both still requesting after done[0] → client 1 acked next. Then client 0 again (alternation).
- Wrap-around: vector store, base 60, wdata[k] = k → writes to addresses 60..63 then 0..15; mem[0] = 4, mem[15] = 19.
- Reset mid-burst: assert rst during XFER of a vector load at idx 7 → immediately busy 0, mem_we 0, vector_data 0; done never pulses. After release, a fresh request is acked normally.
- Late request: client 1 raises req at cycle 3 of a client 0 vector store → ack[1] only in the IDLE cycle after done[0]; no overlap on mem_we.

Source files
------------

// File: rtl/vector_mem_arbiter_if.sv
// Client/memory bundle for vector_mem_arbiter. The master side is the
// environment (both requesters plus the RAM); the slave side is the arbiter.
interface vector_mem_arbiter_if #(
  parameter int I = 20,
  parameter int L = 32,
  parameter int A = 6
);
  logic [1:0]                req;
  logic [1:0]                op_store;
  logic [1:0]                op_vector;
  logic [1:0][A-1:0]         base_address;
  logic [1:0][I-1:0][L-1:0]  wdata;
  logic [1:0]                ack;
  logic [1:0]                done;
  logic                      busy;
  logic [A-1:0]              mem_address;
  logic                      mem_we;
  logic [L-1:0]              mem_wdata;
  logic [L-1:0]              mem_rdata;
  logic [I-1:0][L-1:0]       vector_data;
  logic [L-1:0]              scalar_data;

  modport master (
    output req, op_store, op_vector, base_address, wdata, mem_rdata,
    input  ack, done, busy, mem_address, mem_we, mem_wdata, vector_data, scalar_data
  );

  modport slave (
    input  req, op_store, op_vector, base_address, wdata, mem_rdata,
    output ack, done, busy, mem_address, mem_we, mem_wdata, vector_data, scalar_data
  );
endinterface

// File: rtl/vector_mem_arbiter.sv
// Round-robin sequencer sharing one synchronous single-port data RAM between
// a load client (0) and a store client (1), scalar or I-item vector bursts.
module vector_mem_arbiter #(
  parameter int I = 20,
  parameter int L = 32,
  parameter int A = 6
) (
  input  logic                clk,
  input  logic                rst,
  vector_mem_arbiter_if.slave bus
);
  localparam int CW = $clog2(I + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_r;
  logic                grant_r;
  logic                last_grant_r;
  logic                store_r;
  logic                vector_r;
  logic                rd_valid_r;
  logic                we_r;
  logic [A-1:0]        base_r;
  logic [A-1:0]        addr_r;
  logic [L-1:0]        wd_r;
  logic [I-1:0][L-1:0] wdata_r;
  logic [I-1:0][L-1:0] vdata_r;
  logic [CW-1:0]       idx_r;
  logic [CW-1:0]       rd_idx_r;
  logic [CW-1:0]       last_idx_s;
  logic [CW-1:0]       idx_next_s;
  logic                grant_valid_s;
  logic                grant_sel_s;
  logic [1:0]          ack_s;
  logic [1:0]          done_s;

  // Grant selection in IDLE: a tie goes to the client that did not win last
  always_comb begin
    grant_valid_s = 1'b0;
    grant_sel_s   = 1'b0;
    if ((state_r == IDLE) && !rst) begin
      case (bus.req)
        2'b01: begin
          grant_valid_s = 1'b1;
          grant_sel_s   = 1'b0;
        end
        2'b10: begin
          grant_valid_s = 1'b1;
          grant_sel_s   = 1'b1;
        end
        2'b11: begin
          grant_valid_s = 1'b1;
          grant_sel_s   = ~last_grant_r;
        end
        default: begin
          grant_valid_s = 1'b0;
          grant_sel_s   = 1'b0;
        end
      endcase
    end else begin
      grant_valid_s = 1'b0;
      grant_sel_s   = 1'b0;
    end
  end

  // Burst bounds and handshake pulses decoded from registered state
  always_comb begin
    last_idx_s = {CW{1'b0}};
    idx_next_s = idx_r + CW'(1);
    ack_s      = 2'b00;
    done_s     = 2'b00;
    if (vector_r) begin
      last_idx_s = CW'(I - 1);
    end else begin
      last_idx_s = {CW{1'b0}};
    end
    if (grant_valid_s) begin
      ack_s = grant_sel_s ? 2'b10 : 2'b01;
    end else begin
      ack_s = 2'b00;
    end
    if (state_r == DONE) begin
      done_s = grant_r ? 2'b10 : 2'b01;
    end else begin
      done_s = 2'b00;
    end
  end

  // Sequencer: latch on grant, walk the burst, capture read data one cycle late
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      grant_r      <= 1'b0;
      last_grant_r <= 1'b1;
      store_r      <= 1'b0;
      vector_r     <= 1'b0;
      rd_valid_r   <= 1'b0;
      rd_idx_r     <= {CW{1'b0}};
      idx_r        <= {CW{1'b0}};
      base_r       <= {A{1'b0}};
      addr_r       <= {A{1'b0}};
      we_r         <= 1'b0;
      wd_r         <= {L{1'b0}};
      wdata_r      <= '0;
      vdata_r      <= '0;
    end else begin
      rd_valid_r <= 1'b0;
      if (rd_valid_r) begin
        vdata_r[rd_idx_r] <= bus.mem_rdata;
      end
      case (state_r)
        IDLE: begin
          if (grant_valid_s) begin
            state_r      <= XFER;
            grant_r      <= grant_sel_s;
            last_grant_r <= grant_sel_s;
            store_r      <= bus.op_store[grant_sel_s];
            vector_r     <= bus.op_vector[grant_sel_s];
            base_r       <= bus.base_address[grant_sel_s];
            wdata_r      <= bus.wdata[grant_sel_s];
            idx_r        <= {CW{1'b0}};
            addr_r       <= bus.base_address[grant_sel_s];
            we_r         <= bus.op_store[grant_sel_s];
            wd_r         <= bus.op_store[grant_sel_s] ? bus.wdata[grant_sel_s][0] : {L{1'b0}};
          end
        end
        XFER: begin
          if (!store_r) begin
            rd_valid_r <= 1'b1;
            rd_idx_r   <= idx_r;
          end
          if (idx_r == last_idx_s) begin
            state_r <= store_r ? DONE : DRAIN;
            idx_r   <= {CW{1'b0}};
            addr_r  <= base_r;
            we_r    <= 1'b0;
            wd_r    <= {L{1'b0}};
          end else begin
            idx_r  <= idx_next_s;
            addr_r <= base_r + A'(idx_next_s);
            wd_r   <= store_r ? wdata_r[idx_next_s] : {L{1'b0}};
          end
        end
        DRAIN: begin
          state_r <= DONE;
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          we_r    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ack         = ack_s;
  assign bus.done        = done_s;
  assign bus.busy        = (state_r != IDLE);
  assign bus.mem_address = addr_r;
  assign bus.mem_we      = we_r;
  assign bus.mem_wdata   = wd_r;
  assign bus.vector_data = vdata_r;
  assign bus.scalar_data = vdata_r[0];
endmodule

// File: tb/tb_vector_mem_arbiter.sv
// Scenario bench for vector_mem_arbiter with a behavioural synchronous RAM and
// a write scoreboard; latencies are counted from the ack cycle.
module tb_vector_mem_arbiter;
  localparam int I = 20;
  localparam int L = 32;
  localparam int A = 6;
  localparam int D = 1 << A;

  typedef struct {
    logic [A-1:0] addr;
    logic [L-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  logic preload = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [L-1:0]        mem [D];
  logic [I-1:0][L-1:0] exp_vd;
  logic [I-1:0][L-1:0] done_vd;
  wr_t                 wr_exp_q[$];
  int                  grant_exp_q[$];
  logic [A-1:0]        obs_addr [64];
  logic                obs_we   [64];
  logic [L-1:0]        obs_wd   [64];
  logic                obs_busy [64];

  vector_mem_arbiter_if #(.I(I), .L(L), .A(A)) bus ();
  vector_mem_arbiter #(.I(I), .L(L), .A(A)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // RAM model: read data valid the cycle after the address
  always @(posedge clk) begin
    if (preload) begin
      for (int k = 0; k < D; k++) mem[k] <= 32'(100 + k);
    end else if (bus.mem_we) begin
      mem[bus.mem_address] <= bus.mem_wdata;
    end
    bus.mem_rdata <= mem[bus.mem_address];
  end

  task automatic run_xfer(input int c, input logic st, input logic vec, input logic [A-1:0] base,
                          input logic [I-1:0][L-1:0] wd, output int lat);
    int ack_t;
    ack_t = -1;
    lat   = -1;
    @(posedge clk); #1;
    bus.op_store[c]     = st;
    bus.op_vector[c]    = vec;
    bus.base_address[c] = base;
    bus.wdata[c]        = wd;
    bus.req[c]          = 1'b1;
    for (int t = 0; t < 60 && lat < 0; t++) begin
      @(negedge clk);
      if (ack_t < 0 && bus.ack[c]) ack_t = t;
      if (ack_t >= 0) begin
        obs_addr[t - ack_t] = bus.mem_address;
        obs_we[t - ack_t]   = bus.mem_we;
        obs_wd[t - ack_t]   = bus.mem_wdata;
        obs_busy[t - ack_t] = bus.busy;
        if (bus.done[c]) begin
          lat     = t - ack_t;
          done_vd = bus.vector_data;
        end
      end
      @(posedge clk); #1;
      if (ack_t >= 0) bus.req[c] = 1'b0;
    end
    bus.req[c] = 1'b0;
  endtask

  task automatic test_reset();
    bus.req = 2'b11;
    bus.op_store = 2'b11;
    bus.op_vector = 2'b00;
    bus.base_address[0] = 6'd40;
    bus.base_address[1] = 6'd41;
    bus.wdata[0][0] = 32'h0000_00A0;
    bus.wdata[1][0] = 32'h0000_00A1;
    repeat (3) @(negedge clk);
    n_tests++; if (bus.ack !== 2'b00) begin n_fail++; $display("FAIL reset_ack: got %b want 00", bus.ack); end
    n_tests++; if (bus.done !== 2'b00) begin n_fail++; $display("FAIL reset_done: got %b want 00", bus.done); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_tests++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", bus.mem_we); end
    n_tests++; if (bus.mem_address !== 6'd0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", bus.mem_address); end
    n_tests++; if (bus.mem_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", bus.mem_wdata); end
    n_tests++; if (bus.vector_data !== exp_vd) begin n_fail++; $display("FAIL reset_vdata: item0 got %h want 0", bus.vector_data[0]); end
  endtask

  task automatic test_contention();
    int last_t;
    int seen;
    int exp_c;
    grant_exp_q = {0, 1, 0};
    last_t = -1;
    seen   = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int t = 0; t < 40 && seen < 3; t++) begin
      @(negedge clk);
      if (bus.ack !== 2'b00) begin
        exp_c = grant_exp_q.pop_front();
        n_tests++;
        if (bus.ack !== ((exp_c == 1) ? 2'b10 : 2'b01)) begin
          n_fail++; $display("FAIL contention_order%0d: got ack %b want client %0d", seen, bus.ack, exp_c);
        end
        if (last_t >= 0) begin
          n_tests++;
          if (t - last_t != 3) begin n_fail++; $display("FAIL contention_gap%0d: got %0d want 3", seen, t - last_t); end
        end
        last_t = t;
        seen++;
      end
      @(posedge clk); #1;
      if (seen == 3) bus.req = 2'b00;
    end
    bus.req = 2'b00;
    n_tests++; if (seen != 3) begin n_fail++; $display("FAIL contention_acks: got %0d want 3", seen); end
    for (int t = 0; t < 10 && bus.busy; t++) @(negedge clk);
    @(posedge clk); #1;
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL contention_idle: busy %b want 0", bus.busy); end
  endtask

  task automatic test_vector_load();
    int lat;
    int bad;
    run_xfer(0, 1'b0, 1'b1, 6'd8, '0, lat);
    n_tests++; if (lat != I + 2) begin n_fail++; $display("FAIL vload_latency: got %0d want %0d", lat, I + 2); end
    bad = 0;
    for (int t = 1; t <= I; t++) if (obs_addr[t] !== 6'(8 + t - 1) || obs_busy[t] !== 1'b1) bad++;
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL vload_addr: %0d bad cycles want 0", bad); end
    bad = 0;
    for (int t = 0; t <= lat; t++) if (obs_we[t] !== 1'b0) bad++;
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL vload_we: %0d write cycles want 0", bad); end
    n_tests++; if (obs_busy[0] !== 1'b0) begin n_fail++; $display("FAIL vload_busy_ack: got %b want 0", obs_busy[0]); end
    n_tests++; if (lat > 0 && obs_addr[lat] !== 6'd8) begin n_fail++; $display("FAIL vload_addr_done: got %0d want 8", obs_addr[lat]); end
    for (int k = 0; k < I; k++) exp_vd[k] = 32'(100 + 8 + k);
    n_tests++; if (done_vd !== exp_vd) begin n_fail++; $display("FAIL vload_data: item19 got %0d want %0d", done_vd[19], exp_vd[19]); end
    n_tests++; if (bus.scalar_data !== 32'd108) begin n_fail++; $display("FAIL vload_scalar: got %0d want 108", bus.scalar_data); end
  endtask

  task automatic test_scalar_store_load();
    int lat;
    int nwe;
    wr_t w;
    logic [I-1:0][L-1:0] wd;
    for (int k = 0; k < I; k++) wd[k] = 32'h5500_0000 + 32'(k);
    wd[0] = 32'hDEADBEEF;
    w.addr = 6'd5;
    w.data = 32'hDEADBEEF;
    wr_exp_q.push_back(w);
    run_xfer(1, 1'b1, 1'b0, 6'd5, wd, lat);
    n_tests++; if (lat != 2) begin n_fail++; $display("FAIL sstore_latency: got %0d want 2", lat); end
    nwe = 0;
    for (int t = 0; t <= lat; t++) begin
      if (obs_we[t] === 1'b1) begin
        nwe++;
        if (wr_exp_q.size() > 0) begin
          w = wr_exp_q.pop_front();
          n_tests++;
          if (obs_addr[t] !== w.addr || obs_wd[t] !== w.data) begin
            n_fail++; $display("FAIL sstore_write: got %0d/%h want %0d/%h", obs_addr[t], obs_wd[t], w.addr, w.data);
          end
        end
      end
    end
    n_tests++; if (nwe != 1) begin n_fail++; $display("FAIL sstore_we_count: got %0d want 1", nwe); end
    n_tests++; if (bus.vector_data !== exp_vd) begin n_fail++; $display("FAIL sstore_vdata_kept: item0 got %h want %h", bus.vector_data[0], exp_vd[0]); end
    run_xfer(0, 1'b0, 1'b0, 6'd5, '0, lat);
    n_tests++; if (lat != 3) begin n_fail++; $display("FAIL sload_latency: got %0d want 3", lat); end
    exp_vd[0] = 32'hDEADBEEF;
    n_tests++; if (done_vd !== exp_vd) begin n_fail++; $display("FAIL sload_data: item0 %h item1 %h want %h %h", done_vd[0], done_vd[1], exp_vd[0], exp_vd[1]); end
  endtask

  task automatic test_late_request();
    int a0, a1, d0, d1, nwe, overlap;
    logic [I-1:0][L-1:0] wd;
    for (int k = 0; k < I; k++) wd[k] = 32'(1000 + k);
    bus.op_store = 2'b01;
    bus.op_vector = 2'b01;
    bus.base_address[0] = 6'd30;
    bus.base_address[1] = 6'd9;
    bus.wdata[0] = wd;
    a0 = -1; a1 = -1; d0 = -1; d1 = -1; nwe = 0; overlap = 0;
    @(posedge clk); #1;
    bus.req[0] = 1'b1;
    for (int t = 0; t < 80 && d1 < 0; t++) begin
      @(negedge clk);
      if (a0 < 0 && bus.ack[0]) a0 = t;
      if (a1 < 0 && bus.ack[1]) a1 = t;
      if (d0 < 0 && bus.done[0]) d0 = t;
      if (d1 < 0 && bus.done[1]) begin d1 = t; done_vd = bus.vector_data; end
      if (bus.mem_we) begin nwe++; if (a1 >= 0) overlap++; end
      @(posedge clk); #1;
      if (a0 >= 0) bus.req[0] = 1'b0;
      if (a1 >= 0) bus.req[1] = 1'b0;
      if (a0 >= 0 && t - a0 == 2) bus.req[1] = 1'b1;
    end
    bus.req = 2'b00;
    n_tests++; if (a0 != 0) begin n_fail++; $display("FAIL late_ack0: got %0d want 0", a0); end
    n_tests++; if (d0 - a0 != I + 1) begin n_fail++; $display("FAIL late_done0: got %0d want %0d", d0 - a0, I + 1); end
    n_tests++; if (a1 - a0 != I + 2) begin n_fail++; $display("FAIL late_ack1: got %0d want %0d", a1 - a0, I + 2); end
    n_tests++; if (nwe != I || overlap != 0) begin n_fail++; $display("FAIL late_we: got %0d writes %0d overlap want %0d 0", nwe, overlap, I); end
    n_tests++; if (d1 - a1 != 3) begin n_fail++; $display("FAIL late_done1: got %0d want 3", d1 - a1); end
    exp_vd[0] = 32'd109;
    n_tests++; if (done_vd !== exp_vd) begin n_fail++; $display("FAIL late_data: item0 got %0d want 109", done_vd[0]); end
  endtask

  task automatic test_wrap();
    int lat;
    int nwe;
    wr_t w;
    logic [I-1:0][L-1:0] wd;
    for (int k = 0; k < I; k++) begin
      wd[k] = 32'(k);
      w.addr = A'((60 + k) % D);
      w.data = 32'(k);
      wr_exp_q.push_back(w);
    end
    run_xfer(1, 1'b1, 1'b1, 6'd60, wd, lat);
    n_tests++; if (lat != I + 1) begin n_fail++; $display("FAIL wrap_latency: got %0d want %0d", lat, I + 1); end
    nwe = 0;
    for (int t = 0; t <= lat; t++) begin
      if (obs_we[t] === 1'b1) begin
        nwe++;
        if (wr_exp_q.size() > 0) begin
          w = wr_exp_q.pop_front();
          n_tests++;
          if (obs_addr[t] !== w.addr || obs_wd[t] !== w.data) begin
            n_fail++; $display("FAIL wrap_write%0d: got %0d/%h want %0d/%h", t, obs_addr[t], obs_wd[t], w.addr, w.data);
          end
        end
      end
    end
    n_tests++; if (nwe != I || wr_exp_q.size() != 0) begin n_fail++; $display("FAIL wrap_we_count: got %0d left %0d want %0d 0", nwe, wr_exp_q.size(), I); end
    n_tests++; if (mem[0] !== 32'd4 || mem[15] !== 32'd19) begin n_fail++; $display("FAIL wrap_mem: got %0d %0d want 4 19", mem[0], mem[15]); end
    n_tests++; if (bus.vector_data !== exp_vd) begin n_fail++; $display("FAIL wrap_vdata_kept: item0 got %h want %h", bus.vector_data[0], exp_vd[0]); end
  endtask

  task automatic test_reset_mid_burst();
    int a0, lat, dn;
    bit hit;
    logic [I-1:0][L-1:0] wd;
    bus.op_store[0] = 1'b0;
    bus.op_vector[0] = 1'b1;
    bus.base_address[0] = 6'd16;
    a0 = -1; hit = 1'b0; dn = 0;
    @(posedge clk); #1;
    bus.req[0] = 1'b1;
    for (int t = 0; t < 40 && !hit; t++) begin
      @(negedge clk);
      if (a0 < 0 && bus.ack[0]) a0 = t;
      if (a0 >= 0 && t - a0 == 8) begin
        n_tests++; if (bus.mem_address !== 6'd23) begin n_fail++; $display("FAIL rmid_addr: got %0d want 23", bus.mem_address); end
        rst = 1'b1;
        #1;
        n_tests++; if (bus.busy !== 1'b0 || bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL rmid_busy_we: got %b %b want 0 0", bus.busy, bus.mem_we); end
        n_tests++; if (bus.vector_data !== '0) begin n_fail++; $display("FAIL rmid_vdata: item0 got %h want 0", bus.vector_data[0]); end
        hit = 1'b1;
      end else begin
        @(posedge clk); #1;
        if (a0 >= 0) bus.req[0] = 1'b0;
      end
    end
    bus.req = 2'b00;
    n_tests++; if (!hit) begin n_fail++; $display("FAIL rmid_reached: got %0d want 1", hit); end
    repeat (3) begin @(negedge clk); if (bus.done !== 2'b00) dn++; end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) begin @(negedge clk); if (bus.done !== 2'b00 || bus.busy !== 1'b0) dn++; end
    n_tests++; if (dn != 0) begin n_fail++; $display("FAIL rmid_no_done: got %0d pulses want 0", dn); end
    exp_vd = '0;
    wd = '0;
    wd[0] = 32'hCAFE_F00D;
    run_xfer(1, 1'b1, 1'b0, 6'd50, wd, lat);
    n_tests++; if (lat != 2) begin n_fail++; $display("FAIL rmid_fresh_latency: got %0d want 2", lat); end
    n_tests++; if (mem[50] !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL rmid_fresh_mem: got %h want cafef00d", mem[50]); end
  endtask

  initial begin
    rst = 1'b1;
    bus.req = 2'b00;
    bus.op_store = 2'b00;
    bus.op_vector = 2'b00;
    bus.base_address = '0;
    bus.wdata = '0;
    exp_vd = '0;
    preload = 1'b1;
    @(posedge clk); #1;
    preload = 1'b0;
    test_reset();
    test_contention();
    test_vector_load();
    test_scalar_store_load();
    test_late_request();
    test_wrap();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
